// File: rtl/ccff_ctrl_pkg.sv
// Shared types and helpers for the configuration-chain (ccff) loader.
package ccff_ctrl_pkg;

  localparam int WORD_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_SHIFT,
    ST_FINISH
  } ccff_state_e;

  // Counter must be able to hold CHAIN_LEN itself, not just CHAIN_LEN-1.
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/ccff_word_shifter.sv
// Per-word load/shift register feeding the chain head, plus the tail capture
// register that assembles readback words, indexed by word_bit.
module ccff_word_shifter
  import ccff_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  input  logic              tail_bit,
  output logic              head_bit,
  output logic              word_last,
  output logic [WORD_W-1:0] capture_next
);

  localparam int BIT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] capture_q;
  logic [BIT_W-1:0]  word_bit_q;

  assign head_bit     = shift_q[0];
  assign word_last    = (word_bit_q == BIT_W'(WORD_W - 1));
  // Capture is cleared on every load, so a partial final word reads back zero-padded.
  assign capture_next = capture_q | (WORD_W'(tail_bit) << word_bit_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      capture_q  <= '0;
      word_bit_q <= '0;
    end else if (load) begin
      shift_q    <= load_data;
      capture_q  <= '0;
      word_bit_q <= '0;
    end else if (shift) begin
      shift_q    <= shift_q >> 1;
      capture_q  <= capture_next;
      word_bit_q <= word_bit_q + BIT_W'(1);
    end
  end

endmodule

// File: rtl/ccff_load_ctrl.sv
// Streams bitstream words LSB-first into a ccff configuration chain while
// capturing the previous chain contents from the tail as readback words.
module ccff_load_ctrl
  import ccff_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = WORD_W_DEFAULT
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              cfg_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);

  ccff_state_e       state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              err_q;
  logic              rb_valid_q;
  logic [WORD_W-1:0] rb_data_q;

  logic              load, shift, word_end;
  logic              accept_start, abort_hit, chain_last;
  logic              head_bit, word_last;
  logic [WORD_W-1:0] capture_next;

  assign accept_start = (state_q == ST_IDLE) && start;
  assign abort_hit    = (state_q != ST_IDLE) && abort;
  assign chain_last   = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));

  always_comb begin
    state_d    = state_q;
    word_ready = 1'b0;
    cfg_en     = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    word_end   = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT_WORD;
      end
      ST_WAIT_WORD: begin
        word_ready = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (word_valid) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cfg_en = 1'b1;
          shift  = 1'b1;
          // Chain end takes priority so a partial final word still finishes.
          if (chain_last) begin
            word_end = 1'b1;
            state_d  = ST_FINISH;
          end else if (word_last) begin
            word_end = 1'b1;
            state_d  = ST_WAIT_WORD;
          end
        end
      end
      ST_FINISH: begin
        done    = !abort;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      err_q      <= 1'b0;
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rb_valid_q <= word_end;
      if (word_end) rb_data_q <= capture_next;
      if (accept_start) begin
        bit_cnt_q <= '0;
        err_q     <= 1'b0;
      end else if (shift) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      if (abort_hit) err_q <= 1'b1;
    end
  end

  ccff_word_shifter #(
    .WORD_W(WORD_W)
  ) u_shifter (
    .clk         (prog_clk),
    .rst_n       (prog_reset_n),
    .load        (load),
    .load_data   (word_data),
    .shift       (shift),
    .tail_bit    (ccff_tail),
    .head_bit    (head_bit),
    .word_last   (word_last),
    .capture_next(capture_next)
  );

  assign ccff_head = cfg_en & head_bit;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign rb_valid  = rb_valid_q;
  assign rb_data   = rb_data_q;

endmodule

// File: tb/tb_ccff_load_ctrl.sv
// Two loaders (64- and 40-flop chains) driven against a behavioural chain model;
// expected head stream, readback, final chain and timing come from the load rules.
module tb_ccff_load_ctrl;

  localparam int WW   = 32;
  localparam int LEN0 = 64;
  localparam int LEN1 = 40;

  logic prog_clk = 1'b0;
  logic prog_reset_n;

  logic [1:0] start_s, abort_s, word_valid_s, word_ready_s;
  logic [1:0] ccff_head_s, cfg_en_s, ccff_tail_s;
  logic [1:0] rb_valid_s, busy_s, done_s, err_s;
  logic [1:0][WW-1:0] word_data_s, rb_data_s;

  logic [1:0][63:0] chain;
  logic [1:0]       preload_req;
  logic [63:0]      preload_val;

  int compared   = 0;
  int mismatched = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_load_ctrl #(.CHAIN_LEN(LEN0), .WORD_W(WW)) dut0 (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n),
    .start(start_s[0]), .abort(abort_s[0]),
    .word_data(word_data_s[0]), .word_valid(word_valid_s[0]), .word_ready(word_ready_s[0]),
    .ccff_head(ccff_head_s[0]), .cfg_en(cfg_en_s[0]), .ccff_tail(ccff_tail_s[0]),
    .rb_data(rb_data_s[0]), .rb_valid(rb_valid_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0])
  );

  ccff_load_ctrl #(.CHAIN_LEN(LEN1), .WORD_W(WW)) dut1 (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n),
    .start(start_s[1]), .abort(abort_s[1]),
    .word_data(word_data_s[1]), .word_valid(word_valid_s[1]), .word_ready(word_ready_s[1]),
    .ccff_head(ccff_head_s[1]), .cfg_en(cfg_en_s[1]), .ccff_tail(ccff_tail_s[1]),
    .rb_data(rb_data_s[1]), .rb_valid(rb_valid_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1])
  );

  function automatic int len_of(input int sel);
    return (sel == 0) ? LEN0 : LEN1;
  endfunction

  function automatic logic [63:0] low_mask(input int n);
    return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
  endfunction

  // Chain model: tail is flop 0, head enters at flop len-1, advances only on cfg_en.
  assign ccff_tail_s[0] = chain[0][0];
  assign ccff_tail_s[1] = chain[1][0];

  always @(posedge prog_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (preload_req[i])
        chain[i] <= preload_val;
      else if (cfg_en_s[i])
        chain[i] <= (chain[i] >> 1) | ({63'd0, ccff_head_s[i]} << (len_of(i) - 1));
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag, input int sel);
    checkOutput(tag, 64'({word_ready_s[sel], ccff_head_s[sel], cfg_en_s[sel], rb_valid_s[sel],
                          busy_s[sel], done_s[sel], err_s[sel], rb_data_s[sel]}), 64'd0);
  endtask

  task automatic applyStimulus(input int sel, input logic [63:0] preload,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input int g0, input int g1, input int abort_at,
                               input int reset_at, input bit start_abort);
    int len, cyc, idx, gap_left, cfg_cnt, rb_cnt, done_cnt, done_cyc, abort_cyc, viol;
    int b0, b1, a0, a1, exp_rb0, exp_rb1;
    logic [31:0] w [2];
    logic [31:0] rb_seen [2];
    int rb_cyc [2];
    logic [63:0] head_bits, stream, pre;
    bit finished;

    len = len_of(sel);
    pre = preload & low_mask(len);
    w[0] = w0;
    w[1] = w1;
    stream = {w1, w0};
    idx = 0; gap_left = g0; cfg_cnt = 0; rb_cnt = 0; done_cnt = 0;
    done_cyc = -1; abort_cyc = -1; viol = 0; head_bits = '0; finished = 0;
    rb_seen[0] = '0; rb_seen[1] = '0; rb_cyc[0] = -1; rb_cyc[1] = -1;

    @(negedge prog_clk);
    preload_val = pre;
    preload_req[sel] = 1'b1;
    @(negedge prog_clk);
    preload_req[sel] = 1'b0;

    for (cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (cyc > 0) @(negedge prog_clk);
      start_s[sel] = (cyc == 0) || (abort_cyc < 0 && $urandom_range(0, 5) == 0);
      abort_s[sel] = (cyc == 0 && start_abort) ||
                     (cyc > 0 && abort_at >= 0 && abort_cyc < 0 && cfg_cnt == abort_at &&
                      busy_s[sel] && !word_ready_s[sel]);
      if (cyc > 0 && abort_s[sel]) abort_cyc = cyc;
      if (word_ready_s[sel] && abort_cyc < 0) begin
        if (gap_left > 0 || idx >= 2) begin
          word_valid_s[sel] = 1'b0;
          word_data_s[sel]  = $urandom;
          if (gap_left > 0) gap_left--;
        end else begin
          word_valid_s[sel] = 1'b1;
          word_data_s[sel]  = w[idx];
          idx++;
          gap_left = g1;
        end
      end else begin
        word_valid_s[sel] = 1'($urandom_range(0, 1));
        word_data_s[sel]  = $urandom;
      end

      #1;
      if (!cfg_en_s[sel] && ccff_head_s[sel]) viol++;
      if (cfg_en_s[sel] && word_ready_s[sel]) viol++;
      if (cyc == 0) checkOutput("idle_before_start", 64'(busy_s[sel]), 64'd0);
      if (cyc == 1) begin
        checkOutput("start_accepted", 64'(busy_s[sel]), 64'd1);
        checkOutput("start_clears_err", 64'(err_s[sel]), 64'd0);
      end
      if (cfg_en_s[sel]) begin
        if (cfg_cnt < 64) head_bits = head_bits | ({63'd0, ccff_head_s[sel]} << cfg_cnt);
        cfg_cnt++;
      end
      if (rb_valid_s[sel]) begin
        if (rb_cnt < 2) begin
          rb_seen[rb_cnt] = rb_data_s[sel];
          rb_cyc[rb_cnt]  = cyc;
        end
        rb_cnt++;
      end
      if (done_s[sel]) begin
        done_cnt++;
        done_cyc = cyc;
        finished = 1;
      end
      if (abort_cyc >= 0 && cyc == abort_cyc)
        checkOutput("abort_cfg_en_low", 64'(cfg_en_s[sel]), 64'd0);
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        checkOutput("abort_to_idle", 64'(busy_s[sel]), 64'd0);
        checkOutput("abort_sets_err", 64'(err_s[sel]), 64'd1);
      end
      if (abort_cyc >= 0 && cyc == abort_cyc + 6) finished = 1;
      if (reset_at >= 0 && cfg_cnt == reset_at && cfg_en_s[sel]) begin
        #1 prog_reset_n = 1'b0;
        #1 checkResetOutputs("reset_mid_shift", sel);
        #1 prog_reset_n = 1'b1;
        finished = 1;
      end
    end
    start_s[sel] = 1'b0;
    abort_s[sel] = 1'b0;
    word_valid_s[sel] = 1'b0;

    checkOutput("load_terminated", 64'(finished), 64'd1);
    checkOutput("head_zero_when_disabled", 64'(viol), 64'd0);
    if (reset_at >= 0) return;

    if (abort_cyc >= 0) begin
      checkOutput("abort_cfg_count", 64'(cfg_cnt), 64'(abort_at));
      checkOutput("abort_no_done", 64'(done_cnt), 64'd0);
      checkOutput("abort_no_rb", 64'(rb_cnt), 64'(abort_at / WW));
      checkOutput("abort_err_sticky", 64'(err_s[sel]), 64'd1);
      checkOutput("abort_head_seq", head_bits & low_mask(abort_at), stream & low_mask(abort_at));
      checkOutput("abort_chain", chain[sel],
                  (pre >> abort_at) | ((stream & low_mask(abort_at)) << (len - abort_at)));
    end else begin
      b0 = (len < WW) ? len : WW;
      b1 = len - b0;
      a0 = 1 + g0;
      exp_rb0 = a0 + b0 + 1;
      a1 = exp_rb0 + g1;
      exp_rb1 = a1 + b1 + 1;
      checkOutput("cfg_en_count", 64'(cfg_cnt), 64'(len));
      checkOutput("head_seq", head_bits & low_mask(len), stream & low_mask(len));
      checkOutput("final_chain", chain[sel], stream & low_mask(len));
      checkOutput("rb_count", 64'(rb_cnt), 64'd2);
      checkOutput("rb_word0", 64'(rb_seen[0]), pre & low_mask(b0));
      checkOutput("rb_word1_padded", 64'(rb_seen[1]), (pre >> b0) & low_mask(b1));
      checkOutput("rb0_cycle", 64'(rb_cyc[0]), 64'(exp_rb0));
      checkOutput("rb1_cycle", 64'(rb_cyc[1]), 64'(exp_rb1));
      checkOutput("done_cycle", 64'(done_cyc), 64'(exp_rb1));
      checkOutput("done_count", 64'(done_cnt), 64'd1);
      checkOutput("no_err_after_load", 64'(err_s[sel]), 64'd0);
    end
  endtask

  initial begin
    start_s = '0; abort_s = '0; word_valid_s = '0; word_data_s = '0;
    preload_req = '0; preload_val = '0;
    prog_reset_n = 1'b0;
    repeat (3) @(negedge prog_clk);
    #1;
    checkResetOutputs("reset_state0", 0);
    checkResetOutputs("reset_state1", 1);
    prog_reset_n = 1'b1;

    $display("[TB] directed: 64-flop chain, back-to-back words");
    applyStimulus(0, 64'h1234_5678_9ABC_DEF0, 32'hA5A5_0001, 32'hFFFF_0000, 0, 0, -1, -1, 0);
    $display("[TB] directed: 40-flop chain, partial final word");
    applyStimulus(1, {$urandom, $urandom}, 32'h0000_00FF, 32'h0000_00AB, 0, 0, -1, -1, 0);
    $display("[TB] directed: 10-cycle word starvation");
    applyStimulus(0, 64'h1234_5678_9ABC_DEF0, 32'hA5A5_0001, 32'hFFFF_0000, 0, 10, -1, -1, 0);
    $display("[TB] directed: abort at shift bit 20, then start with abort");
    applyStimulus(0, {$urandom, $urandom}, $urandom, $urandom, 0, 0, 20, -1, 0);
    applyStimulus(0, {$urandom, $urandom}, $urandom, $urandom, 0, 0, -1, -1, 1);
    $display("[TB] directed: reset pulse mid-shift, then reload");
    applyStimulus(1, {$urandom, $urandom}, $urandom, $urandom, 0, 0, -1, 13, 0);
    applyStimulus(1, {$urandom, $urandom}, $urandom, $urandom, 0, 0, -1, -1, 0);

    $display("[TB] randomized loads");
    for (int n = 0; n < 12; n++) begin
      applyStimulus(int'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom, $urandom,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
